// File: rtl/note_plotter_8.sv
// note_plotter_8: redraws one lane's note block on a VGA adapter.
// When the upstream y position changes, the block at the previous row is
// erased pixel by pixel, then the block is drawn at the new row. Pixels are
// emitted one per clock in raster order (cx fastest, then cy).
module note_plotter_8 #(
   parameter logic [8:0] X_BASE      = 9'd40,
   parameter int         BLK_W       = 8,
   parameter int         BLK_H       = 4,
   parameter logic [2:0] NOTE_COLOUR = 3'b100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       data_en,
   input  logic [7:0] data,
   output logic [8:0] x,
   output logic [7:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ERASE = 2'd1,
      DRAW  = 2'd2
   } state_t;

   localparam logic [3:0] CX_LAST = 4'(BLK_W - 1);
   localparam logic [3:0] CY_LAST = 4'(BLK_H - 1);

   state_t     state;
   state_t     state_next;
   logic [7:0] last_y;
   logic [7:0] new_y;
   logic       drawn;
   logic [3:0] cx;
   logic [3:0] cy;
   // Set once the final DRAW pixel has been emitted; the following cycle
   // closes the sequence (done pulse, last_y update) and returns to IDLE.
   logic       draw_end;
   logic       trigger;
   logic       blk_last;

   // Trigger detection, block-end detection and next-state selection
   always_comb begin
      trigger    = data_en && (!drawn || (data != last_y));
      blk_last   = (cx == CX_LAST) && (cy == CY_LAST);
      state_next = state;
      case (state)
         IDLE: begin
            if (trigger) begin
               state_next = drawn ? ERASE : DRAW;
            end
         end
         ERASE: begin
            if (blk_last) begin
               state_next = DRAW;
            end
         end
         DRAW: begin
            if (draw_end) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Datapath: block counters, row bookkeeping and registered pixel outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         last_y   <= 8'd0;
         new_y    <= 8'd0;
         drawn    <= 1'b0;
         cx       <= 4'd0;
         cy       <= 4'd0;
         draw_end <= 1'b0;
         x        <= 9'd0;
         y        <= 8'd0;
         colour   <= 3'b000;
         plot     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         plot <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (trigger) begin
                  new_y <= data;
                  cx    <= 4'd0;
                  cy    <= 4'd0;
               end
            end
            ERASE: begin
               x      <= X_BASE + {5'd0, cx};
               y      <= last_y + {4'd0, cy};
               colour <= 3'b000;
               plot   <= 1'b1;
               busy   <= 1'b1;
               if (blk_last) begin
                  cx <= 4'd0;
                  cy <= 4'd0;
               end else if (cx == CX_LAST) begin
                  cx <= 4'd0;
                  cy <= cy + 4'd1;
               end else begin
                  cx <= cx + 4'd1;
               end
            end
            DRAW: begin
               if (draw_end) begin
                  draw_end <= 1'b0;
                  done     <= 1'b1;
                  last_y   <= new_y;
                  drawn    <= 1'b1;
               end else begin
                  x      <= X_BASE + {5'd0, cx};
                  y      <= new_y + {4'd0, cy};
                  colour <= NOTE_COLOUR;
                  plot   <= 1'b1;
                  busy   <= 1'b1;
                  if (blk_last) begin
                     draw_end <= 1'b1;
                     cx       <= 4'd0;
                     cy       <= 4'd0;
                  end else if (cx == CX_LAST) begin
                     cx <= 4'd0;
                     cy <= cy + 4'd1;
                  end else begin
                     cx <= cx + 4'd1;
                  end
               end
            end
            default: begin
               draw_end <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_note_plotter_8.sv
// tb_note_plotter_8: directed checks of the note block erase/draw sequencer.
// A negedge monitor logs every plotted pixel; each scenario then compares
// the logged pixels against hand-derived block coordinates.
module tb_note_plotter_8;

   logic       clk = 1'b0;
   logic       reset;
   logic       data_en;
   logic [7:0] data;
   logic [8:0] x;
   logic [7:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       busy;
   logic       done;

   int total = 0;
   int bad   = 0;

   int cycleCnt  = 0;
   int pixCount  = 0;
   int busyCount = 0;
   int doneCount = 0;
   logic [19:0] cap      [0:1023];
   int          capCycle [0:1023];

   int pixBase;
   int busyBase;
   int doneBase;
   int startCycle;

   note_plotter_8 dut (
      .clk     (clk),
      .reset   (reset),
      .data_en (data_en),
      .data    (data),
      .x       (x),
      .y       (y),
      .colour  (colour),
      .plot    (plot),
      .busy    (busy),
      .done    (done)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Monitor: log plotted pixels and count busy/done cycles away from the active edge
   always @(negedge clk) begin
      cycleCnt <= cycleCnt + 1;
      if (plot) begin
         if (pixCount < 1024) begin
            cap[pixCount]      <= {x, y, colour};
            capCycle[pixCount] <= cycleCnt + 1;
         end
         pixCount <= pixCount + 1;
      end
      if (busy) busyCount <= busyCount + 1;
      if (done) doneCount <= doneCount + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
      total++;
      if (got !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic en, input logic [7:0] d);
      data_en = en;
      data    = d;
      tick();
   endtask

   task automatic clearCapture();
      pixBase    = pixCount;
      busyBase   = busyCount;
      doneBase   = doneCount;
      startCycle = cycleCnt;
   endtask

   task automatic waitDone(input string tag, input int target, input int budget);
      int n;
      n = 0;
      while (((doneCount - doneBase) < target) && (n < budget)) begin
         tick();
         n++;
      end
      checkOutput({tag, "_timeout"}, 32'((doneCount - doneBase) >= target), 32'd1);
      repeat (3) tick();
   endtask

   // Compare a logged erase+draw run against the expected block raster
   task automatic checkSeq(input string tag, input int offset, input int nErase,
                           input logic [7:0] eraseBase, input logic [7:0] drawBase);
      logic [8:0] ex;
      logic [7:0] ey;
      logic [2:0] ec;
      int         j;
      for (int i = 0; i < nErase + 32; i++) begin
         if (i < nErase) begin
            j  = i;
            ey = eraseBase + 8'(j / 8);
            ec = 3'b000;
         end else begin
            j  = i - nErase;
            ey = drawBase + 8'(j / 8);
            ec = 3'b100;
         end
         ex = 9'd40 + 9'(j % 8);
         checkOutput($sformatf("%s_pix%0d", tag, i), 32'(cap[pixBase + offset + i]), 32'({ex, ey, ec}));
      end
   endtask

   initial begin
      int n;
      reset   = 1'b1;
      data_en = 1'b0;
      data    = 8'd0;
      repeat (3) tick();
      checkOutput("rst_x",      32'(x),      32'd0);
      checkOutput("rst_y",      32'(y),      32'd0);
      checkOutput("rst_colour", 32'(colour), 32'd0);
      checkOutput("rst_plot",   32'(plot),   32'd0);
      checkOutput("rst_busy",   32'(busy),   32'd0);
      checkOutput("rst_done",   32'(done),   32'd0);
      reset = 1'b0;
      tick();

      $display("[TB] first draw at 160");
      clearCapture();
      applyStimulus(1'b1, 8'd160);
      waitDone("first", 1, 100);
      checkOutput("first_cnt",     32'(pixCount - pixBase),   32'd32);
      checkOutput("first_done",    32'(doneCount - doneBase), 32'd1);
      checkOutput("first_busy",    32'(busyCount - busyBase), 32'd32);
      checkOutput("first_latency", 32'(capCycle[pixBase] - startCycle), 32'd3);
      checkSeq("first", 0, 0, 8'd0, 8'd160);

      $display("[TB] move 160 to 164");
      clearCapture();
      applyStimulus(1'b1, 8'd164);
      waitDone("move", 1, 150);
      checkOutput("move_cnt",     32'(pixCount - pixBase),   32'd64);
      checkOutput("move_busy",    32'(busyCount - busyBase), 32'd64);
      checkOutput("move_done",    32'(doneCount - doneBase), 32'd1);
      checkOutput("move_latency", 32'(capCycle[pixBase] - startCycle), 32'd3);
      checkOutput("move_contig",  32'(capCycle[pixCount - 1] - capCycle[pixBase] + 1), 32'd64);
      checkSeq("move", 0, 32, 8'd160, 8'd164);

      $display("[TB] wrap 176 to 160");
      clearCapture();
      applyStimulus(1'b1, 8'd176);
      waitDone("to176", 1, 150);
      checkSeq("to176", 0, 32, 8'd164, 8'd176);
      clearCapture();
      applyStimulus(1'b1, 8'd160);
      waitDone("wrap", 1, 150);
      checkOutput("wrap_cnt", 32'(pixCount - pixBase), 32'd64);
      checkSeq("wrap", 0, 32, 8'd176, 8'd160);
      clearCapture();
      repeat (10) tick();
      checkOutput("wrap_lasty_hold", 32'(pixCount - pixBase), 32'd0);

      $display("[TB] change during draw");
      clearCapture();
      applyStimulus(1'b1, 8'd164);
      n = 0;
      while (((pixCount - pixBase) < 42) && (n < 100)) begin
         tick();
         n++;
      end
      checkOutput("mid_reach", 32'((pixCount - pixBase) >= 42), 32'd1);
      applyStimulus(1'b1, 8'd168);
      waitDone("mid", 2, 400);
      checkOutput("mid_cnt",  32'(pixCount - pixBase),   32'd128);
      checkOutput("mid_done", 32'(doneCount - doneBase), 32'd2);
      checkSeq("mid_a", 0, 32, 8'd160, 8'd164);
      checkSeq("mid_b", 64, 32, 8'd164, 8'd168);

      $display("[TB] reset during erase");
      clearCapture();
      applyStimulus(1'b1, 8'd172);
      n = 0;
      while (((pixCount - pixBase) < 5) && (n < 50)) begin
         tick();
         n++;
      end
      checkOutput("rstmid_reach", 32'((pixCount - pixBase) >= 5), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("rstmid_plot", 32'(plot), 32'd0);
      checkOutput("rstmid_busy", 32'(busy), 32'd0);
      checkOutput("rstmid_x",    32'(x),    32'd0);
      clearCapture();
      waitDone("rstdraw", 1, 100);
      checkOutput("rstdraw_cnt", 32'(pixCount - pixBase), 32'd32);
      checkSeq("rstdraw", 0, 0, 8'd0, 8'd172);

      $display("[TB] hold with unchanged data and with data_en low");
      clearCapture();
      repeat (100) tick();
      checkOutput("hold_same_cnt",  32'(pixCount - pixBase),   32'd0);
      checkOutput("hold_same_busy", 32'(busyCount - busyBase), 32'd0);
      clearCapture();
      for (int i = 0; i < 50; i++) begin
         applyStimulus(1'b0, 8'(i * 5));
      end
      checkOutput("hold_en0_cnt",  32'(pixCount - pixBase),   32'd0);
      checkOutput("hold_en0_busy", 32'(busyCount - busyBase), 32'd0);
      checkOutput("hold_x",        32'(x),      32'd47);
      checkOutput("hold_y",        32'(y),      32'd175);
      checkOutput("hold_colour",   32'(colour), 32'd4);

      $display("[TB] y wrap modulo 256");
      clearCapture();
      applyStimulus(1'b1, 8'd254);
      waitDone("ywrap", 1, 150);
      checkOutput("ywrap_cnt", 32'(pixCount - pixBase), 32'd64);
      checkSeq("ywrap", 0, 32, 8'd172, 8'd254);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/note_plotter_8.md
NOTE_PLOTTER_8 -- requirements
Module: note_plotter_8

Interface
REQ-001 Parameter X_BASE, default 9'd40: left pixel column of the lane's note block.
REQ-002 Parameter BLK_W, default 8: block width in pixels, range 1..16.
REQ-003 Parameter BLK_H, default 4: block height in pixels, range 1..16.
REQ-004 Parameter NOTE_COLOUR, default 3'b100: draw colour; erase colour is fixed at 3'b000.
REQ-005 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port data_en, input, 1: upstream position-valid flag, driven by the note-position generator.
REQ-008 Port data, input, 8: upstream note top-row y coordinate (nominal 160..176, step 4).
REQ-009 Port x, output, 9: pixel column to the VGA adapter, registered.
REQ-010 Port y, output, 8: pixel row to the VGA adapter, registered.
REQ-011 Port colour, output, 3: pixel colour, registered.
REQ-012 Port plot, output, 1: pixel write strobe; one pixel per cycle while high.
REQ-013 Port busy, output, 1: high while in ERASE or DRAW.
REQ-014 Port done, output, 1: one-cycle pulse on the cycle after the last DRAW pixel.

Function
REQ-015 States: IDLE, ERASE, DRAW.
- Internal registers: last_y[7:0], drawn (1 bit), new_y[7:0], cx[3:0], cy[3:0].
REQ-016 IDLE trigger: data_en=1 and (drawn=0 or data!=last_y).
- On trigger, capture new_y<=data and clear cx, cy.
- Next state is ERASE if drawn=1, otherwise DRAW.
REQ-017 IDLE with no trigger: plot=0, busy=0; all registers hold.
REQ-018 ERASE: one pixel per cycle, raster order (cx fastest, then cy).
- Pixel values: x=X_BASE+cx, y=last_y+cy, colour=3'b000, plot=1.
REQ-019 ERASE exit: after pixel (BLK_W-1, BLK_H-1), move to DRAW with cx, cy cleared; no idle cycle between phases.
REQ-020 DRAW: same raster order.
- Pixel values: x=X_BASE+cx, y=new_y+cy, colour=NOTE_COLOUR, plot=1.
REQ-021 DRAW exit: after the last pixel, the next cycle is IDLE with plot=0 and done=1.
- Same edge: last_y<=new_y, drawn<=1.
REQ-022 Latency: trigger sampled at edge T gives the first pixel on outputs after edge T+1.
- Move with defaults: plot high for 64 consecutive cycles (32 erase, then 32 draw).
- First draw (drawn=0): plot high for 32 cycles.
REQ-023 data and data_en changes during ERASE/DRAW are ignored, with no queueing.
- The IDLE comparison against last_y catches any net change on return to IDLE.
- A new sequence may start on the cycle done is high.
REQ-024 Arithmetic:
- x is 9-bit unsigned, no overflow for X_BASE<=320-BLK_W.
- y is 8-bit unsigned and wraps modulo 256 (data=8'd254, cy=3 gives y=8'd1).
REQ-025 Wrap-around upstream (data 176->160) is an ordinary change: erase at 176, draw at 160.
REQ-026 data_en=0 in IDLE never triggers, regardless of data.
REQ-027 When plot=0, x, y and colour hold their last values.

Reset
REQ-028 While reset=1 at an edge, from any state:
- state<=IDLE, drawn<=0, last_y<=8'd0, new_y<=8'd0, cx<=0, cy<=0.
- Outputs: x<=9'd0, y<=8'd0, colour<=3'b000, plot<=0, busy<=0, done<=0.
REQ-029 Reset mid-ERASE/DRAW abandons the sequence without finishing the erase.
- The first post-reset trigger takes the DRAW-only path.
REQ-030 reset has priority over every other input in the same cycle.

Verification
REQ-031 First draw. Stimulus: after reset, data_en=1, data=160.
- 32 plots: x 40..47, y 160..163, colour 3'b100.
- done pulses once; no pixel with colour 000.
REQ-032 Move. Stimulus: data 160->164.
- 32 erase pixels at y 160..163, colour 000.
- Immediately followed by 32 draw pixels at y 164..167, colour 100.
- busy high for exactly 64 cycles.
REQ-033 Wrap. Stimulus: data 176->160.
- Erase rows 176..179, then draw rows 160..163.
- last_y=160 afterwards.
REQ-034 Change mid-draw. Stimulus: data goes 164->168 at cycle 10 of the DRAW phase.
- The current sequence completes unchanged at 164.
- On the done cycle a new trigger fires: erase 164, draw 168.
REQ-035 Reset mid-ERASE. Stimulus: reset=1 for 1 cycle, then data_en=1 with data=172.
- plot=0 on the cycle after reset.
- Then 32 draw-only pixels at rows 172..175.
REQ-036 Hold. Stimulus: data_en=1 with data unchanged for 100 cycles after a draw; also data_en=0 with data varying.
- plot remains 0 and busy remains 0 throughout.
